// File: rtl/ram4k_arb_pkg.sv
// rtl/ram4k_arb_pkg.sv - shared constants for the ram4k two-port arbiter
package ram4k_arb_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way picker, round-robin on ties
// RAM4K_ARB_FIXED_PRIO_EN selects fixed priority (A always beats B).
module rr_pick2
  import ram4k_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

`ifdef RAM4K_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign grant = req[PORT_A] ? PORT_A : PORT_B;
`else
  always_comb begin
    grant = PORT_A;
    if (req[PORT_A] && req[PORT_B]) begin
      grant = ~last;
    end else if (req[PORT_B]) begin
      grant = PORT_B;
    end
  end
`endif

endmodule

// File: rtl/ram4k_arbiter.sv
// rtl/ram4k_arbiter.sv - shares one ram4k between ports A and B, one word per transaction
// RAM4K_ARB_FIXED_PRIO_EN removes the round-robin pointer (A has fixed priority).
module ram4k_arbiter
  import ram4k_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  logic [1:0] state;
  logic       win;
  logic       last;
  logic       grant;

  rr_pick2 u_pick (
    .req   ({b_req, a_req}),
    .last  (last),
    .grant (grant)
  );

`ifdef RAM4K_ARB_FIXED_PRIO_EN
  assign last = PORT_B;
`else
  // Reset to "B granted last" so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= PORT_B;
    end else if (state == ACK) begin
      last <= win;
    end
  end
`endif

  // The RAM pins double as the latched transaction: they hold between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      win         <= PORT_A;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      ram_load    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      busy        <= 1'b0;
    end else begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      ram_load <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            win         <= grant;
            ram_address <= (grant == PORT_B) ? b_addr  : a_addr;
            ram_in      <= (grant == PORT_B) ? b_wdata : a_wdata;
            ram_load    <= (grant == PORT_B) ? b_we    : a_we;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // ram_out is sampled on the same edge that commits a write: pre-write data.
          if (win == PORT_B) begin
            b_rdata <= ram_out;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= ram_out;
            a_ack   <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram4k_arbiter.md
# ram4k_arbiter

Two-port arbiter and sequencer that shares one `ram4k` (4K x 16) between requesters A and B. Each requester issues single-word read or write transactions over a req/ack handshake. The arbiter picks one winner per transaction, drives the RAM's `in`/`address`/`load` pins for exactly one cycle, captures `out`, and returns an ack plus read data. It sits between the RAM and two masters, for example the CPU data port and a DMA/debug port.

## Interface
- `ADDR_W`, 12, address width; matches `ram4k`.
- `DATA_W`, 16, data width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `a_req`  in  1  A requests a transaction; held high until `a_ack`.
- `a_we`  in  1  1 = write, 0 = read; held stable while `a_req` is high.
- `a_addr`  in  ADDR_W  word address.
- `a_wdata`  in  DATA_W  write data.
- `a_ack`  out  1  one-cycle completion pulse.
- `a_rdata`  out  DATA_W  RAM word read; valid while `a_ack` is high.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as the A port, for B.
- `ram_in`  out  DATA_W  connects to `ram4k.in`.
- `ram_address`  out  ADDR_W  connects to `ram4k.address`.
- `ram_load`  out  1  connects to `ram4k.load`.
- `ram_out`  in  DATA_W  connects to `ram4k.out`. Read is combinational on `address`; a write commits on the `clk` edge while `load`=1.
- `busy`  out  1  high in ACCESS and ACK.

## Operation
- FSM states: IDLE, ACCESS, ACK.
  - **IDLE:** if `a_req` or `b_req` is high, pick the winner and latch its `we`, `addr` and `wdata`, then go to ACCESS. Otherwise stay in IDLE.
  - **ACCESS:** drive `ram_address` and `ram_in` from the latched values and drive `ram_load` = latched `we` for this cycle only. Register `ram_out` into rdata, then go to ACK.
  - **ACK:** pulse the winner's ack for one cycle with rdata valid. Update the round-robin pointer to the winner, then go to IDLE.
- **Arbitration:** round-robin. When both requests are high, the port that was not granted last wins. A single request wins unconditionally.
- **Write rdata:** rdata on a write ack is the pre-write content, because the read happens before the write.
- **Outside ACCESS:** `ram_load` is 0. `ram_address` and `ram_in` hold their last driven values.
- **Losing port:** its ack stays 0 and its rdata holds its previous value.
- **req dropped before ack:** the latched transaction still completes and the ack still pulses.
- **req held high after ack:** treated as a new transaction at the next IDLE.
- **Reset values:** state=IDLE, `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, `ram_load`=0, `ram_address`=0, `ram_in`=0, `busy`=0, pointer = "B granted last", so A wins the first tie.
- **Reset asserted mid-transaction:** the transaction is abandoned with no ack. `ram_load` falls immediately, so a write in ACCESS is not committed unless the `clk` edge precedes reset. The requester must reissue.

## Timing
- Sample request at edge N (IDLE). ACCESS runs in cycle N+1 (`ram_load` high there for a write). Ack is high in cycle N+2.
- Latency is 3 cycles from req high at an IDLE edge to ack high. Maximum throughput is one transaction per 3 cycles.
- With both requesters saturated, grants alternate A, B, A, B, … Worst-case wait is 6 cycles.
- All outputs are registered; there is no combinational path from req to ack.

## Configuration
- `RAM4K_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority, A always beats B. The pointer logic is removed and B can starve under continuous A requests.
  - **Undefined (default):** round-robin as above.

## Structure
- Package `ram4k_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2);
  - the `ADDR_W` and `DATA_W` defaults;
  - the port-select constants PORT_A=1'b0 and PORT_B=1'b1.
- Sub-module `rr_pick2`: combinational 2-way picker with inputs `req[1:0]` and `last` and output `grant`. The `RAM4K_ARB_FIXED_PRIO_EN` macro switches it to fixed priority.

## Test plan
- **Reset:** assert `reset` mid-stream. All outputs are 0 and the state is IDLE within the same cycle, with no clock edge needed.
- **Single write:** A writes 16'hBEEF to address 12'h0A5. `ram_load`=1 only in cycle N+1. `a_ack` is high in N+2 and `b_ack` stays 0.
- **Read-back:** B reads 12'h0A5. `b_ack` is high 3 cycles after the request with `b_rdata`=16'hBEEF.
- **Contention:** A and B both hold req continuously for 8 transactions. Grants alternate A,B,A,B,… starting with A after reset, and the ack spacing is 3 cycles. With `RAM4K_ARB_FIXED_PRIO_EN` defined, all 8 acks go to A.
- **Write rdata:** A writes 16'h1234 to 12'hFFF, which holds 16'h0000. `a_rdata`=16'h0000 at ack, and a subsequent read returns 16'h1234.
- **Boundary:** A reads 12'h000 and B reads 12'hFFF back-to-back. A reset pulse during A's ACCESS (write) leaves the RAM content unchanged, produces no ack, and the reissued write completes normally.
